sobel_line_buffer: RTL and testbench

Upstream neighbour of the Sobel edge stage. It accepts a raster-order grey-scale pixel stream (row-major, one pixel per accepted beat) and keeps the two previous image rows in line memories. Once at least three rows and three columns are available, it emits one complete 3x3 neighbourhood per accepted pixel on a valid/ready interface. The Sobel stage then consumes a full window per beat instead of re-loading nine pixels serially.

---
 rtl/sobel_pkg.sv | 25 ++
 rtl/sobel_line_ram.sv | 27 ++
 rtl/sobel_line_buffer.sv | 124 ++++++++++++
 tb/tb_sobel_line_buffer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel front end: image geometry defaults,
// 3x3 window element indices and counter sizing.
package sobel_pkg;

   localparam int DW_DEF = 8;
   localparam int H_DEF  = 200;
   localparam int W_DEF  = 160;

   // Window element (i,j) lives at bits [(3*i+j)*DW +: DW]
   localparam int WIN_00 = 0;
   localparam int WIN_01 = 1;
   localparam int WIN_02 = 2;
   localparam int WIN_10 = 3;
   localparam int WIN_11 = 4;
   localparam int WIN_12 = 5;
   localparam int WIN_20 = 6;
   localparam int WIN_21 = 7;
   localparam int WIN_22 = 8;
   localparam int WIN_N  = 9;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sobel_line_ram.sv
// One image line of storage: asynchronous read, synchronous write at the
// same address, so a read in the write cycle returns the old contents.
module sobel_line_ram
   import sobel_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int DW = DW_DEF
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [cnt_width(W)-1:0] addr,
   input  logic [DW-1:0]           wdata,
   output logic [DW-1:0]           rdata
);

   logic [DW-1:0] mem_r [W];

   // Line storage write; contents are never reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= wdata;
      end
   end

   assign rdata = mem_r[addr];

endmodule

// File: rtl/sobel_line_buffer.sv
// Raster pixel stream to 3x3 neighbourhood stream, using two line memories
// holding the previous two rows.
module sobel_line_buffer
   import sobel_pkg::*;
#(
   parameter int H  = H_DEF,
   parameter int W  = W_DEF,
   parameter int DW = DW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DW-1:0]   pix_in,
   input  logic            pix_valid,
   output logic            pix_ready,
   output logic [9*DW-1:0] win_out,
   output logic            win_valid,
   input  logic            win_ready,
   output logic            win_last,
   output logic            frame_done
);

   localparam int CW = cnt_width(W);
   localparam int RW = cnt_width(H);
   localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   logic [CW-1:0]      col_r, col_nxt_s;
   logic [RW-1:0]      row_r, row_nxt_s;
   logic [9*DW-1:0]    win_r, win_nxt_s;
   logic               win_valid_r, win_last_r, frame_done_r;
   logic [DW-1:0]      lb1_rd_s, lb2_rd_s;
   logic               accept_s, col_last_s, row_last_s, is_last_s, emit_s;

   assign pix_ready  = !(win_valid_r && !win_ready);
   assign accept_s   = pix_valid && pix_ready;
   assign col_last_s = (col_r == COL_LAST);
   assign row_last_s = (row_r == ROW_LAST);
   assign is_last_s  = col_last_s && row_last_s;
   // Columns 0-1 of a row would pair with stale columns of the previous row
   assign emit_s     = (row_r >= ROW_TWO) && (col_r >= COL_TWO);

   assign win_out    = win_r;
   assign win_valid  = win_valid_r;
   assign win_last   = win_last_r;
   assign frame_done = frame_done_r;

   sobel_line_ram #(.W(W), .DW(DW)) u_lb1 (
      .clk   (clk),
      .we    (accept_s),
      .addr  (col_r),
      .wdata (pix_in),
      .rdata (lb1_rd_s)
   );

   sobel_line_ram #(.W(W), .DW(DW)) u_lb2 (
      .clk   (clk),
      .we    (accept_s),
      .addr  (col_r),
      .wdata (lb1_rd_s),
      .rdata (lb2_rd_s)
   );

   // Next raster position, wrapping column then row
   always_comb begin
      col_nxt_s = col_r;
      row_nxt_s = row_r;
      if (col_last_s) begin
         col_nxt_s = {CW{1'b0}};
         if (row_last_s) begin
            row_nxt_s = {RW{1'b0}};
         end else begin
            row_nxt_s = row_r + RW'(1);
         end
      end else begin
         col_nxt_s = col_r + CW'(1);
      end
   end

   // Shift window left and insert the new right-hand column
   always_comb begin
      win_nxt_s = win_r;
      for (int i = 0; i < 3; i++) begin
         win_nxt_s[(3*i+0)*DW +: DW] = win_r[(3*i+1)*DW +: DW];
         win_nxt_s[(3*i+1)*DW +: DW] = win_r[(3*i+2)*DW +: DW];
      end
      win_nxt_s[WIN_02*DW +: DW] = lb2_rd_s;
      win_nxt_s[WIN_12*DW +: DW] = lb1_rd_s;
      win_nxt_s[WIN_22*DW +: DW] = pix_in;
   end

   // Position counters and window register advance only on accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_r <= {CW{1'b0}};
         row_r <= {RW{1'b0}};
         win_r <= {(9*DW){1'b0}};
      end else if (accept_s) begin
         col_r <= col_nxt_s;
         row_r <= row_nxt_s;
         win_r <= win_nxt_s;
      end
   end

   // Output qualifiers; held while the downstream stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_valid_r  <= 1'b0;
         win_last_r   <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         frame_done_r <= accept_s && is_last_s;
         if (accept_s) begin
            win_valid_r <= emit_s;
            win_last_r  <= is_last_s;
         end else if (win_ready) begin
            win_valid_r <= 1'b0;
            win_last_r  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sobel_line_buffer.sv
// Directed bench for sobel_line_buffer on a 5x4 image with pixel r*16+c.
module tb_sobel_line_buffer;

   localparam int H  = 4;
   localparam int W  = 5;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] pix_in;
   logic          pix_valid;
   logic          pix_ready;
   logic [71:0]   win_out;
   logic          win_valid;
   logic          win_ready;
   logic          win_last;
   logic          frame_done;

   int total = 0;
   int bad   = 0;
   int idx   = 0;

   typedef struct {
      logic pv;
      logic wr;
      logic pr;
      logic wv;
      logic wl;
      logic fd;
      int   r0;
      int   c0;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   sobel_line_buffer #(.H(H), .W(W), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .win_out    (win_out),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_last   (win_last),
      .frame_done (frame_done)
   );

   function automatic logic [7:0] pixval(input int k);
      return 8'(((k / W) * 16) + (k % W));
   endfunction

   function automatic logic [71:0] exp_win(input int r0, input int c0);
      logic [71:0] w;
      w = 72'd0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[(3*i+j)*8 +: 8] = 8'(((r0 + i) * 16) + (c0 + j));
      return w;
   endfunction

   function automatic void add(input logic pv, input logic wr, input logic pr,
                               input logic wv, input logic wl, input logic fd,
                               input int r0, input int c0);
      vec_t v;
      v.pv = pv; v.wr = wr; v.pr = pr; v.wv = wv;
      v.wl = wl; v.fd = fd; v.r0 = r0; v.c0 = c0;
      vecs.push_back(v);
   endfunction

   // One accept slot of a continuous stream at raster position k
   function automatic void add_pix(input int k);
      int r;
      int c;
      r = k / W;
      c = k % W;
      add(1'b1, 1'b1, 1'b1, (r >= 2 && c >= 2), (k == H*W-1), (k == H*W-1), r - 2, c - 2);
   endfunction

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at posedge+1: drive, check ready, clock, check outputs
   task automatic run_vec(input vec_t v);
      logic acc;
      pix_valid = v.pv;
      win_ready = v.wr;
      pix_in    = pixval(idx);
      #1;
      check("pix_ready", {71'd0, pix_ready}, {71'd0, v.pr});
      acc = pix_valid && pix_ready;
      @(posedge clk);
      #1;
      if (acc) idx = (idx + 1) % (H * W);
      check("win_valid", {71'd0, win_valid}, {71'd0, v.wv});
      check("win_last", {71'd0, win_last}, {71'd0, v.wl});
      check("frame_done", {71'd0, frame_done}, {71'd0, v.fd});
      if (v.wv) check("win_out", win_out, exp_win(v.r0, v.c0));
   endtask

   initial begin
      // Frames 1 and 2: continuous flow, back to back
      for (int f = 0; f < 2; f++)
         for (int k = 0; k < H*W; k++) add_pix(k);
      // Frame 3: stall 3 cycles once the first window appears
      for (int k = 0; k <= 12; k++) add_pix(k);
      for (int s = 0; s < 3; s++) add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      for (int k = 13; k < H*W; k++) add_pix(k);
      // Frame 4: pix_valid toggles, idle cycles carry no window
      for (int k = 0; k < H*W; k++) begin
         add_pix(k);
         add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      end

      rst       = 1'b1;
      pix_valid = 1'b0;
      win_ready = 1'b1;
      pix_in    = 8'd0;
      #1;
      check("rst pix_ready", {71'd0, pix_ready}, 72'd1);
      check("rst win_valid", {71'd0, win_valid}, 72'd0);
      check("rst win_last", {71'd0, win_last}, 72'd0);
      check("rst frame_done", {71'd0, frame_done}, 72'd0);
      check("rst win_out", win_out, 72'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;

      foreach (vecs[n]) run_vec(vecs[n]);

      // Mid-frame reset right after pixel (2,3) produced window (0,1)
      idx = 0;
      for (int k = 0; k <= 13; k++) begin
         vec_t v;
         v.pv = 1'b1; v.wr = 1'b1; v.pr = 1'b1;
         v.wv = ((k / W) >= 2 && (k % W) >= 2);
         v.wl = 1'b0; v.fd = 1'b0; v.r0 = k / W - 2; v.c0 = k % W - 2;
         run_vec(v);
      end
      pix_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("async rst win_valid", {71'd0, win_valid}, 72'd0);
      check("async rst win_out", win_out, 72'd0);
      check("async rst pix_ready", {71'd0, pix_ready}, 72'd1);
      check("async rst win_last", {71'd0, win_last}, 72'd0);
      check("async rst frame_done", {71'd0, frame_done}, 72'd0);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      idx = 0;
      for (int k = 0; k <= 12; k++) begin
         vec_t v;
         v.pv = 1'b1; v.wr = 1'b1; v.pr = 1'b1;
         v.wv = (k == 12);
         v.wl = 1'b0; v.fd = 1'b0; v.r0 = 0; v.c0 = 0;
         run_vec(v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
